gpsreceiver2_tx: RTL

- Playback transmitter for the GPS front-end serial interface. It is the sending end of the receiver's IQ nibble stream.
- Reads bytes from a 2048x8 sample buffer and serializes them as the SiGe SE4162T-style clock/sync/data triple.
- Sync marks the first bit of each nibble (IIQQ), the low nibble goes out first, and bits go out LSB first. A connected receiver therefore rebuilds the same byte {hi,lo}.
- Used for loopback test of the receiver and for replaying recorded captures.

---
 rtl/gpsreceiver2_pkg.sv | 20 ++
 rtl/gpsreceiver2_tx_bitclk.sv | 38 +++
 rtl/gpsreceiver2_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gpsreceiver2_pkg.sv
// Shared state encodings and constants for the GPS front-end serial playback path.
package gpsreceiver2_pkg;

    localparam int unsigned DefaultAdrW = 11;

    // Sync marks bit 0 of each IIQQ nibble: positions 0 and 4 within a byte.
    localparam logic [2:0] SyncBitLo = 3'd0;
    localparam logic [2:0] SyncBitHi = 3'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPrime = 2'd1,
        StShift = 2'd2
    } tx_state_e;

    function automatic logic is_sync_bit(input logic [2:0] bit_idx);
        return (bit_idx == SyncBitLo) || (bit_idx == SyncBitHi);
    endfunction

endpackage

// File: rtl/gpsreceiver2_tx_bitclk.sv
// Bit-period timer: gps_tx_clk is low for CLKDIV cycles then high for CLKDIV cycles,
// with single-cycle strobes on the first and last cycle of each bit period.
module gpsreceiver2_tx_bitclk #(
    parameter int unsigned CLKDIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tx_clk,
    output logic bit_start,
    output logic bit_end
);

    localparam int unsigned Period = 2 * CLKDIV;
    localparam int unsigned CntW   = $clog2(Period);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (en && !bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bit_start = en && (cnt_q == '0);
    assign bit_end   = en && (cnt_q == CntW'(Period - 1));
    assign tx_clk    = en && (cnt_q >= CntW'(CLKDIV));

endmodule

// File: rtl/gpsreceiver2_tx.sv
// Playback transmitter: serializes buffer bytes as clock/sync/data, LSB first.
// Define GPSRECEIVER2_TX_LOOP_EN to replay the buffer continuously until stop.
module gpsreceiver2_tx
    import gpsreceiver2_pkg::*;
#(
    parameter int unsigned CLKDIV = 2,
    parameter int unsigned ADR_W  = DefaultAdrW
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             stop,
    input  logic [ADR_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [ADR_W-1:0] byte_count,
    output logic [ADR_W-1:0] txb_adr,
    input  logic [7:0]       txb_dat,
    output logic             gps_tx_clk,
    output logic             gps_tx_sync,
    output logic             gps_tx_data
);

    tx_state_e        state_q, state_d;
    logic [ADR_W-1:0] len_q, adr_q, count_q, adr_adv;
    logic [7:0]       shift_q, hold_q;
    logic [2:0]       bit_q;
    logic             stop_q, done_q;
    logic             bit_clk, bit_start, bit_end;
    logic             byte_end, last_byte, go;

    gpsreceiver2_tx_bitclk #(
        .CLKDIV(CLKDIV)
    ) u_bitclk (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (state_q == StShift),
        .tx_clk   (bit_clk),
        .bit_start(bit_start),
        .bit_end  (bit_end)
    );

    assign go       = start && (len != '0);
    assign byte_end = bit_end && (bit_q == 3'd7);

`ifdef GPSRECEIVER2_TX_LOOP_EN
    assign last_byte = stop_q || stop;
    always_comb begin
        adr_adv = adr_q + ADR_W'(1);
        if (adr_adv == len_q) begin
            adr_adv = '0;
        end
    end
`else
    // count_q is the index of the byte on the wire, so len-1 marks the final byte.
    assign last_byte = stop_q || stop || (count_q == len_q - ADR_W'(1));
    always_comb begin
        adr_adv = adr_q + ADR_W'(1);
        if (adr_q == len_q) begin
            adr_adv = adr_q;
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (go) state_d = StPrime;
            StPrime: state_d = StShift;
            StShift: if (byte_end && last_byte) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            len_q   <= '0;
            adr_q   <= '0;
            count_q <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go) begin
                        len_q   <= len;
                        adr_q   <= '0;
                        count_q <= '0;
                        stop_q  <= 1'b0;
                    end
                end
                StPrime: begin
                    shift_q <= txb_dat;
                    adr_q   <= adr_adv;
                    bit_q   <= '0;
                end
                StShift: begin
                    if (stop) stop_q <= 1'b1;
                    // Prefetched byte is read late in bit 0; the address moves on in bit 1.
                    if (bit_end && bit_q == SyncBitLo) hold_q <= txb_dat;
                    if (bit_start && bit_q == 3'd1) adr_q <= adr_adv;
                    if (bit_end) begin
                        bit_q   <= bit_q + 3'd1;
                        shift_q <= shift_q >> 1;
                    end
                    if (byte_end) begin
                        shift_q <= hold_q;
                        count_q <= count_q + ADR_W'(1);
                        if (last_byte) begin
                            done_q <= 1'b1;
                            adr_q  <= '0;
                            stop_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done        = done_q;
        byte_count  = count_q;
        txb_adr     = adr_q;
        gps_tx_clk  = bit_clk;
        gps_tx_sync = 1'b0;
        gps_tx_data = 1'b0;
        if (state_q == StShift) begin
            gps_tx_sync = is_sync_bit(bit_q);
            gps_tx_data = shift_q[0];
        end
    end

endmodule
